// File: rtl/io_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// io_ctrl_pkg
// Types and constants shared by the io_ctrl encoder path.
//   enc_dir_t   : decoded detent direction (NONE / UP / DOWN)
//   ENC_SPEED_W : width of the acceleration speed multiplier
//   decode_dir  : turns raw up/down pulses into a direction; both or neither
//                 high yields DIR_NONE
// -----------------------------------------------------------------------------
package io_ctrl_pkg;

   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_UP   = 2'd1,
      DIR_DOWN = 2'd2
   } enc_dir_t;

   localparam int ENC_SPEED_W = 3;

   function automatic enc_dir_t decode_dir(input logic up_i, input logic down_i);
      enc_dir_t dir;
      case ({up_i, down_i})
         2'b10:   dir = DIR_UP;
         2'b01:   dir = DIR_DOWN;
         default: dir = DIR_NONE;
      endcase
      return dir;
   endfunction

endpackage

// File: rtl/encoder_accel.sv
// -----------------------------------------------------------------------------
// encoder_accel
// Tracks the spacing of same-direction detents and produces the speed
// multiplier for the detent presented in the current cycle.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear      : recenter; forget direction history and drop to speed 1
//   evt_valid  : a detent is accepted this cycle
//   evt_dir    : its direction (UP/DOWN when evt_valid)
//   speed      : multiplier to apply to this cycle's detent (combinational)
// -----------------------------------------------------------------------------
module encoder_accel
   import io_ctrl_pkg::*;
#(
   parameter int ACCEL_WIN = 250000,
   parameter int ACCEL_MAX = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   evt_valid,
   input  enc_dir_t               evt_dir,
   output logic [ENC_SPEED_W-1:0] speed
);

   localparam int                     GAP_W     = $clog2(ACCEL_WIN + 1);
   localparam logic [GAP_W-1:0]       GAP_SAT   = GAP_W'(ACCEL_WIN);
   localparam logic [GAP_W-1:0]       GAP_ONE   = GAP_W'(1);
   localparam logic [ENC_SPEED_W-1:0] SPEED_ONE = ENC_SPEED_W'(1);
   localparam logic [ENC_SPEED_W-1:0] SPEED_MAX = ENC_SPEED_W'(ACCEL_MAX);

   logic [GAP_W-1:0]       gap_r;
   enc_dir_t               last_dir_r;
   logic [ENC_SPEED_W-1:0] speed_r;
   logic [ENC_SPEED_W-1:0] speed_s;
   logic                   fast_s;

   // Speed for the current detent: ramp only on a quick repeat in the same direction.
   always_comb begin
      fast_s  = 1'b0;
      speed_s = SPEED_ONE;
      // last_dir_r is NONE after reset/recenter, so the first detent never counts as fast
      fast_s = evt_valid && (evt_dir == last_dir_r) && (gap_r < GAP_SAT);
      if (fast_s) begin
         if (speed_r < SPEED_MAX) begin
            speed_s = speed_r + SPEED_ONE;
         end else begin
            speed_s = SPEED_MAX;
         end
      end else begin
         speed_s = SPEED_ONE;
      end
   end

   assign speed = speed_s;

   // Gap counter, last direction and current speed history.
   always_ff @(posedge clk) begin
      if (reset) begin
         gap_r      <= GAP_SAT;
         last_dir_r <= DIR_NONE;
         speed_r    <= SPEED_ONE;
      end else if (clear) begin
         // a detent coincident with recenter is dropped, so the gap keeps running
         last_dir_r <= DIR_NONE;
         speed_r    <= SPEED_ONE;
         if (gap_r < GAP_SAT) begin
            gap_r <= gap_r + GAP_ONE;
         end else begin
            gap_r <= GAP_SAT;
         end
      end else if (evt_valid) begin
         gap_r      <= '0;
         last_dir_r <= evt_dir;
         speed_r    <= speed_s;
      end else begin
         if (gap_r < GAP_SAT) begin
            gap_r <= gap_r + GAP_ONE;
         end else begin
            // window expired: a stale spin no longer carries any speed
            speed_r <= SPEED_ONE;
         end
      end
   end

endmodule

// File: rtl/paddle_position.sv
// -----------------------------------------------------------------------------
// paddle_position
// Turns encoder detent pulses into a saturating paddle position, with an
// optional speed-dependent acceleration and a frame-stable copy of the value.
// Build option: define PADDLE_ACCEL_EN to include the acceleration logic
// (encoder_accel); otherwise every detent moves exactly STEP.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   up, down    : one-cycle detent pulses (both together are ignored)
//   recenter    : reload POS_INIT; wins over a coincident detent
//   frame_tick  : capture the current pos into pos_frame
//   pos         : live position (registered)
//   pos_frame   : position sampled at the last frame_tick
//   moved       : one-cycle flag, pos took a new value
//   at_min/max  : pos sits on POS_MIN / POS_MAX
// -----------------------------------------------------------------------------
module paddle_position
   import io_ctrl_pkg::*;
#(
   parameter int POS_W     = 10,
   parameter int POS_MIN   = 0,
   parameter int POS_MAX   = 600,
   parameter int POS_INIT  = 300,
   parameter int STEP      = 2,
   parameter int ACCEL_WIN = 250000,
   parameter int ACCEL_MAX = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             up,
   input  logic             down,
   input  logic             recenter,
   input  logic             frame_tick,
   output logic [POS_W-1:0] pos,
   output logic [POS_W-1:0] pos_frame,
   output logic             moved,
   output logic             at_min,
   output logic             at_max
);

   // Four guard bits keep pos +/- (STEP*speed) free of wrap-around.
   localparam int                      AW         = POS_W + 4;
   localparam logic signed [AW-1:0]    POS_MIN_W  = AW'(POS_MIN);
   localparam logic signed [AW-1:0]    POS_MAX_W  = AW'(POS_MAX);
   localparam logic [POS_W-1:0]        POS_MIN_V  = POS_W'(POS_MIN);
   localparam logic [POS_W-1:0]        POS_MAX_V  = POS_W'(POS_MAX);
   localparam logic [POS_W-1:0]        POS_INIT_V = POS_W'(POS_INIT);

   if (!(POS_MIN < POS_MAX) || (POS_MAX >= (2 ** POS_W)) || (POS_INIT < POS_MIN) ||
       (POS_INIT > POS_MAX) || (STEP < 1) || (ACCEL_WIN < 1) || (ACCEL_MAX < 1) ||
       (ACCEL_MAX >= (2 ** ENC_SPEED_W))) begin : g_cfg_err
      $error("paddle_position: illegal parameter set");
   end

   enc_dir_t               evt_dir_s;
   logic [ENC_SPEED_W-1:0] speed_s;
   logic signed [AW-1:0]   pos_wide_s;
   logic signed [AW-1:0]   step_s;
   logic signed [AW-1:0]   sum_s;
   logic signed [AW-1:0]   diff_s;
   logic [POS_W-1:0]       pos_next_s;

   logic [POS_W-1:0]       pos_r;
   logic [POS_W-1:0]       pos_frame_r;
   logic                   moved_r;
   logic                   at_min_r;
   logic                   at_max_r;

   assign evt_dir_s = decode_dir(up, down);

`ifdef PADDLE_ACCEL_EN
   logic evt_valid_s;
   assign evt_valid_s = (evt_dir_s != DIR_NONE);

   encoder_accel #(
      .ACCEL_WIN (ACCEL_WIN),
      .ACCEL_MAX (ACCEL_MAX)
   ) u_accel (
      .clk       (clk),
      .reset     (reset),
      .clear     (recenter),
      .evt_valid (evt_valid_s),
      .evt_dir   (evt_dir_s),
      .speed     (speed_s)
   );
`else
   assign speed_s = ENC_SPEED_W'(1);
`endif

   // Next position: recenter first, then a clamped step in the detent direction.
   always_comb begin
      pos_wide_s = $signed({4'b0000, pos_r});
      step_s     = AW'(STEP * int'(speed_s));
      sum_s      = pos_wide_s + step_s;
      diff_s     = pos_wide_s - step_s;
      pos_next_s = pos_r;
      if (recenter) begin
         pos_next_s = POS_INIT_V;
      end else begin
         case (evt_dir_s)
            DIR_UP: begin
               if (sum_s > POS_MAX_W) begin
                  pos_next_s = POS_MAX_V;
               end else begin
                  pos_next_s = sum_s[POS_W-1:0];
               end
            end
            DIR_DOWN: begin
               if (diff_s < POS_MIN_W) begin
                  pos_next_s = POS_MIN_V;
               end else begin
                  pos_next_s = diff_s[POS_W-1:0];
               end
            end
            default: pos_next_s = pos_r;
         endcase
      end
   end

   // Position register with change flag, limit flags and frame snapshot.
   always_ff @(posedge clk) begin
      if (reset) begin
         pos_r       <= POS_INIT_V;
         pos_frame_r <= POS_INIT_V;
         moved_r     <= 1'b0;
         at_min_r    <= (POS_INIT_V == POS_MIN_V);
         at_max_r    <= (POS_INIT_V == POS_MAX_V);
      end else begin
         pos_r    <= pos_next_s;
         moved_r  <= (pos_next_s != pos_r);
         at_min_r <= (pos_next_s == POS_MIN_V);
         at_max_r <= (pos_next_s == POS_MAX_V);
         // snapshot takes the value held during this cycle, not the update
         if (frame_tick) begin
            pos_frame_r <= pos_r;
         end else begin
            pos_frame_r <= pos_frame_r;
         end
      end
   end

   assign pos       = pos_r;
   assign pos_frame = pos_frame_r;
   assign moved     = moved_r;
   assign at_min    = at_min_r;
   assign at_max    = at_max_r;

endmodule

// File: tb/tb_paddle_position.sv
// Directed scoreboard bench for paddle_position. ACCEL_WIN is shortened to
// 200 cycles so "slow" (300-cycle) and "fast" (10-cycle) spins stay short.
module tb_paddle_position;

`ifdef PADDLE_ACCEL_EN
   localparam bit ACC = 1'b1;
`else
   localparam bit ACC = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic       up;
   logic       down;
   logic       recenter;
   logic       frame_tick;
   logic [9:0] pos;
   logic [9:0] pos_frame;
   logic       moved;
   logic       at_min;
   logic       at_max;

   paddle_position #(
      .POS_W     (10),
      .POS_MIN   (0),
      .POS_MAX   (600),
      .POS_INIT  (300),
      .STEP      (2),
      .ACCEL_WIN (200),
      .ACCEL_MAX (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .up         (up),
      .down       (down),
      .recenter   (recenter),
      .frame_tick (frame_tick),
      .pos        (pos),
      .pos_frame  (pos_frame),
      .moved      (moved),
      .at_min     (at_min),
      .at_max     (at_max)
   );

   typedef struct {
      string name;
      int    cyc;
      int    pos;
      int    frame;
      bit    moved;
      bit    at_min;
      bit    at_max;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc       = 0;
   int   n_cmp     = 0;
   int   n_bad     = 0;
   int   cur_pos   = 300;
   int   frame_exp = 300;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation that falls due in this cycle.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         mon_e = sb.pop_front();
         n_cmp = n_cmp + 1;
         if (mon_e.cyc != cyc || int'(pos) != mon_e.pos || int'(pos_frame) != mon_e.frame ||
             moved !== mon_e.moved || at_min !== mon_e.at_min || at_max !== mon_e.at_max) begin
            n_bad = n_bad + 1;
            $display("FAIL %s @cyc %0d: got pos=%0d frame=%0d moved=%b min=%b max=%b, expected pos=%0d frame=%0d moved=%b min=%b max=%b",
                     mon_e.name, cyc, pos, pos_frame, moved, at_min, at_max,
                     mon_e.pos, mon_e.frame, mon_e.moved, mon_e.at_min, mon_e.at_max);
         end
      end
   end

   task automatic push_exp(input string nm, input int epos, input bit emov);
      exp_t e;
      e.name   = nm;
      e.cyc    = cyc + 1;
      e.pos    = epos;
      e.frame  = frame_exp;
      e.moved  = emov;
      e.at_min = (epos == 0);
      e.at_max = (epos == 600);
      sb.push_back(e);
      cur_pos = epos;
   endtask

   // One cycle of stimulus; result expected right after the next edge.
   task automatic drive(input bit u, input bit d, input bit rc, input bit ft,
                        input string nm, input int epos, input bit emov);
      up = u; down = d; recenter = rc; frame_tick = ft;
      if (ft) frame_exp = cur_pos;
      push_exp(nm, epos, emov);
      @(posedge clk); #1;
      up = 1'b0; down = 1'b0; recenter = 1'b0; frame_tick = 1'b0;
   endtask

   task automatic do_reset(input string nm);
      reset = 1'b1;
      frame_exp = 300;
      push_exp(nm, 300, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int fast_a[6] = '{302, 306, 312, 320, 328, 336};
   int spd;
   int nxt;

   initial begin
      up = 1'b0; down = 1'b0; recenter = 1'b0; frame_tick = 1'b0; reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      do_reset("reset_state");

      // slow spin: every detent is a plain STEP
      for (int i = 1; i <= 5; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0, "slow_up", 300 + 2 * i, 1'b1);
         if (i == 1) drive(1'b0, 1'b0, 1'b0, 1'b0, "moved_one_cycle", 302, 1'b0);
         idle(300);
      end

      // fast spin from 300
      drive(1'b0, 1'b0, 1'b1, 1'b0, "recenter_310", 300, 1'b1);
      idle(10);
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0, "fast_up", ACC ? fast_a[i] : 302 + 2 * i, 1'b1);
         idle(9);
      end
      drive(1'b0, 1'b1, 1'b0, 1'b0, "reverse_down", ACC ? 334 : 310, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b0, "recenter", 300, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b0, "recenter_same", 300, 1'b0);

      // back-to-back ups into the upper limit
      spd = 0;
      for (int i = 0; i < 150; i++) begin
         spd = ACC ? ((spd >= 4) ? 4 : spd + 1) : 1;
         nxt = cur_pos + 2 * spd;
         if (nxt > 600) nxt = 600;
         drive(1'b1, 1'b0, 1'b0, 1'b0, "ramp_up", nxt, nxt != cur_pos);
      end
      drive(1'b0, 1'b1, 1'b0, 1'b0, "down_to_598", 598, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 1'b0, "up_to_max", 600, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 1'b0, "up_at_max", 600, 1'b0);

      // back-to-back downs into the lower limit
      drive(1'b0, 1'b0, 1'b1, 1'b0, "recenter_600", 300, 1'b1);
      spd = 0;
      for (int i = 0; i < 150; i++) begin
         spd = ACC ? ((spd >= 4) ? 4 : spd + 1) : 1;
         nxt = cur_pos - 2 * spd;
         if (nxt < 0) nxt = 0;
         drive(1'b0, 1'b1, 1'b0, 1'b0, "ramp_down", nxt, nxt != cur_pos);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, "up_from_min", 2, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 1'b0, "both_ignored", 2, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, "up_after_both", ACC ? 6 : 4, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 1'b0, "reverse_step", ACC ? 4 : 2, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 1'b0, "down_to_min", 0, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 1'b0, "down_at_min", 0, 1'b0);

      // recenter beats a coincident detent and clears speed
      drive(1'b1, 1'b0, 1'b1, 1'b0, "recenter_with_up", 300, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 1'b0, "up_after_recenter", 302, 1'b1);

      // frame snapshot takes the pre-update value
      idle(300);
      drive(1'b1, 1'b0, 1'b0, 1'b1, "frame_with_up", 304, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b1, "frame_only", 304, 1'b0);

      // reset in the middle of a fast spin
      drive(1'b1, 1'b0, 1'b0, 1'b0, "accel_a", ACC ? 308 : 306, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 1'b0, "accel_b", ACC ? 314 : 308, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 1'b0, "accel_c", ACC ? 322 : 310, 1'b1);
      do_reset("reset_mid_accel");
      drive(1'b1, 1'b0, 1'b0, 1'b0, "up_after_reset", 302, 1'b1);

      for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
      if (sb.size() > 0) begin
         n_cmp = n_cmp + 1;
         n_bad = n_bad + 1;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #10000000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/paddle_position.md
# paddle_position

Converts the single-cycle `up`/`down` step pulses from the rotary-encoder front end into a bounded, saturating paddle position for the game logic. Sits directly downstream of the encoder sense stage in `io_ctrl`. Optional speed-dependent acceleration lets fast spins cover the play field quickly. Provides a frame-stable copy of the position for the video/game domain.

## Interface
- `POS_W`, 10: position width in bits.
- `POS_MIN`, 0: lowest legal position.
- `POS_MAX`, 600: highest legal position; must satisfy `POS_MIN < POS_MAX < 2**POS_W`.
- `POS_INIT`, 300: value loaded on reset and on `recenter`.
- `STEP`, 2: base increment per detent.
- `ACCEL_WIN`, 250000: max cycle gap between same-direction detents that still counts as "fast".
- `ACCEL_MAX`, 4: max speed multiplier.

- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high reset.
- `up` input 1: one-cycle detent pulse, increasing direction.
- `down` input 1: one-cycle detent pulse, decreasing direction.
- `recenter` input 1: one-cycle pulse, reload `POS_INIT`.
- `frame_tick` input 1: one-cycle pulse at frame start; latches `pos_frame`.
- `pos` output POS_W: live position.
- `pos_frame` output POS_W: position sampled at last `frame_tick`.
- `moved` output 1: high for one cycle when `pos` takes a new value.
- `at_min` output 1: `pos == POS_MIN`.
- `at_max` output 1: `pos == POS_MAX`.

## Operation
- Reset: `pos = pos_frame = POS_INIT`, `moved = 0`, `at_min`/`at_max` per `POS_INIT`, speed = 1, gap counter saturated, last direction = NONE.
- Event decode per cycle: `up & !down` → UP; `down & !up` → DOWN; both or neither → no event (both high is ignored and does not touch accel state).
- Priority: `recenter` > detent event. `recenter` loads `POS_INIT`, sets speed = 1, last direction = NONE; a coincident detent is dropped.
- Step size = `STEP * speed`. UP: `pos = min(pos + step, POS_MAX)`; DOWN: `pos = max(pos - step, POS_MIN)`. Arithmetic done at `POS_W+4` bits signed, no wrap-around. Already at a limit in the pushing direction → `pos` unchanged, `moved = 0`.
- Acceleration (when enabled): gap counter resets to 0 on every accepted detent, increments otherwise, saturates at `ACCEL_WIN`. On a detent, speed for *that* detent: same direction as last and gap < `ACCEL_WIN` → `min(speed+1, ACCEL_MAX)`; otherwise 1. Gap reaching `ACCEL_WIN` forces speed = 1. Direction reversal always gives speed 1.
- `moved` = 1 exactly when the registered `pos` differs from its previous value (including `recenter` from a different value).
- `frame_tick`: `pos_frame` takes the current registered `pos` (value before any update in the same cycle).

## Timing
- Detent at cycle N → new `pos`, `moved`, `at_min`/`at_max` visible at N+1. Single register stage, no back-pressure.
- Back-to-back detents on consecutive cycles are all accepted.
- `frame_tick` at N → `pos_frame` updated at N+1 with `pos` as seen during N.
- Reset asserted mid-acceleration returns to reset state on the next edge; no residual speed.

## Configuration
- `PADDLE_ACCEL_EN` defined: acceleration logic and gap counter present as described.
- Not defined: speed fixed at 1, every detent moves exactly `STEP`; `ACCEL_WIN`/`ACCEL_MAX` accepted but unused; no gap counter synthesised.

## Structure
- `io_ctrl_pkg`: `typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} enc_dir_t`; shared `ENC_SPEED_W` constant (multiplier width).
- One sub-module, `encoder_accel`: event direction + gap counter → speed multiplier; instantiated only under `PADDLE_ACCEL_EN`.

## Test plan
- Reset then 5 `up` pulses spaced 300000 cycles (accel on, defaults) → `pos` 302,304,306,308,310; `moved` pulse after each.
- 6 `up` pulses 1000 cycles apart from 300 → steps 2,4,6,8,8,8 → final `pos` 336; a `down` next → step 2, `pos` 334.
- From `pos` 598, `up` → 600, `at_max` = 1; further `up` → 600, `moved` = 0. Mirror at `POS_MIN` with `down`.
- `up` and `down` high same cycle → no change, no `moved`; `recenter` with coincident `up` at `pos` 450 → `pos` 300, `moved` = 1, next fast `up` steps 2.
- `frame_tick` same cycle as `up` at `pos` 320 → `pos_frame` 320, `pos` 322; without `PADDLE_ACCEL_EN`, 6 fast `up` from 300 → 312.
